cte_scheduler: RTL and testbench
================================

CTE_SCHEDULER -- requirements
Module: cte_scheduler

Interface
REQ-001 Parameter BURST_LEN, default 16, pixels per job (range 1..255).
REQ-002 Parameter TIMEOUT, default 255, drain watchdog limit in cycles (used only with CTE_SCHED_TIMEOUT_EN).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 y_req  input  1  YUV source requests a YUV->RGB job.
REQ-006 y_valid / y_data  input  1 / 8  YUV byte stream (Y,U,Y,V order).
REQ-007 y_ready  output  1  YUV byte accepted when y_valid&y_ready.
REQ-008 r_req  input  1  RGB source requests an RGB->YUV job.
REQ-009 r_valid / r_data  input  1 / 24  RGB pixel stream.
REQ-010 r_ready  output  1  RGB pixel accepted when r_valid&r_ready.
REQ-011 cte_busy / cte_out_valid  input  1 / 1  CTE status.
REQ-012 cte_op_mode / cte_in_en  output  1 / 1  CTE control (op_mode 0 = YUV->RGB, 1 = RGB->YUV).
REQ-013 cte_yuv_in / cte_rgb_in  output  8 / 24  CTE data inputs.
REQ-014 owner  output  1  current job owner (0 = YUV, 1 = RGB).
REQ-015 job_done  output  1  one-cycle pulse at job completion.
REQ-016 job_err  output  1  one-cycle pulse on watchdog abort.

Function
REQ-017 FSM states IDLE, SETUP, FEED, DRAIN; encoded registered state.
REQ-018 IDLE: if exactly one of y_req/r_req high, grant it; if both, grant the requester not served last (round-robin; after reset YUV wins first tie).
REQ-019 IDLE->SETUP on grant: owner and cte_op_mode registered; in_cnt and out_cnt cleared; SETUP lasts exactly 1 cycle, then FEED.
REQ-020 FEED: y_ready = (owner==0)&!cte_busy&(in_cnt<2*BURST_LEN); r_ready = (owner==1)&!cte_busy&(in_cnt<BURST_LEN); combinational.
REQ-021 cte_in_en = accepted transfer this cycle (combinational); cte_yuv_in/cte_rgb_in forward owner data on transfer, drive 0 otherwise; non-owner data bus always 0.
REQ-022 in_cnt increments per accepted transfer; FEED->DRAIN in the cycle after the last input (2*BURST_LEN bytes YUV, BURST_LEN pixels RGB).
REQ-023 out_cnt increments on every cte_out_valid in FEED or DRAIN; expected outputs: BURST_LEN (YUV job), 2*BURST_LEN (RGB job).
REQ-024 DRAIN->IDLE when out_cnt reaches expected count (including the cycle the final cte_out_valid arrives); job_done pulses in that cycle.
REQ-025 cte_out_valid in IDLE/SETUP ignored; out_cnt saturates at expected count.
REQ-026 Requester deasserting req mid-job has no effect; job runs to completion.
REQ-027 New grant evaluated no earlier than the cycle after returning to IDLE (one idle cycle between jobs).
REQ-028 cte_op_mode held constant from SETUP through DRAIN.

Reset
REQ-029 reset low: state=IDLE, owner=0, cte_op_mode=0, counters=0, last-served=RGB, job_done=0, job_err=0, all ready/in_en low, data outputs 0 -- immediately, independent of clk.
REQ-030 Reset mid-job abandons the job without job_done; first cycle after release is IDLE.

Configuration
REQ-031 Macro CTE_SCHED_TIMEOUT_EN defined: idle counter in DRAIN resets on each cte_out_valid; at TIMEOUT cycles without one, go IDLE, pulse job_err, no job_done.
REQ-032 Macro undefined: no watchdog logic; DRAIN waits indefinitely; job_err tied 0.

Verification
REQ-033 BURST_LEN=4, y_req only, 8 bytes 0x10..0x17, cte_busy=0 -> op_mode=0, 8 in_en pulses with matching data, 4 out_valids -> job_done once, owner=0.
REQ-034 r_req only, 4 pixels 0x102030.. -> op_mode=1, 4 in_en, 8 out_valids -> job_done; y_ready never high.
REQ-035 y_req and r_req both high from reset -> YUV job, then RGB job, then YUV job (alternation verified over 3 jobs).
REQ-036 cte_busy high 3 cycles mid-FEED -> y_ready/cte_in_en low those 3 cycles, no byte lost or duplicated, in_cnt unchanged.
REQ-037 reset low during DRAIN with 2 outputs pending -> outputs at reset values asynchronously, no job_done, next grant starts clean.
REQ-038 With CTE_SCHED_TIMEOUT_EN, TIMEOUT=10, withhold last out_valid -> job_err pulse 10 cycles after last output, state IDLE; without macro, scheduler stays in DRAIN.

Source files
------------

// File: rtl/cte_scheduler_if.sv
// rtl/cte_scheduler_if.sv - YUV/RGB source streams and CTE control/status bundle for cte_scheduler
interface cte_scheduler_if;
  logic        y_req;
  logic        y_valid;
  logic [7:0]  y_data;
  logic        y_ready;
  logic        r_req;
  logic        r_valid;
  logic [23:0] r_data;
  logic        r_ready;
  logic        cte_busy;
  logic        cte_out_valid;
  logic        cte_op_mode;
  logic        cte_in_en;
  logic [7:0]  cte_yuv_in;
  logic [23:0] cte_rgb_in;
  logic        owner;
  logic        job_done;
  logic        job_err;

  modport slave (
    input  y_req, y_valid, y_data, r_req, r_valid, r_data, cte_busy, cte_out_valid,
    output y_ready, r_ready, cte_op_mode, cte_in_en, cte_yuv_in, cte_rgb_in,
           owner, job_done, job_err
  );

  modport master (
    output y_req, y_valid, y_data, r_req, r_valid, r_data, cte_busy, cte_out_valid,
    input  y_ready, r_ready, cte_op_mode, cte_in_en, cte_yuv_in, cte_rgb_in,
           owner, job_done, job_err
  );
endinterface

// File: rtl/cte_scheduler.sv
// rtl/cte_scheduler.sv - round-robin YUV/RGB job scheduler for the CTE; CTE_SCHED_TIMEOUT_EN adds a drain watchdog
module cte_scheduler #(
  parameter int BURST_LEN = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic           clk,
  input  logic           reset,
  cte_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    FEED  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // YUV jobs take two bytes per pixel and return one result per pixel;
  // RGB jobs take one pixel and return two YUV bytes per pixel.
  localparam logic [8:0] YUV_IN_LEN  = 9'(2 * BURST_LEN);
  localparam logic [8:0] RGB_IN_LEN  = 9'(BURST_LEN);
  localparam logic [8:0] YUV_OUT_LEN = 9'(BURST_LEN);
  localparam logic [8:0] RGB_OUT_LEN = 9'(2 * BURST_LEN);

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       op_mode_q, op_mode_d;
  logic       last_rgb_q, last_rgb_d;
  logic [8:0] in_cnt_q, in_cnt_d;
  logic [8:0] out_cnt_q, out_cnt_d;

  logic       y_ready, r_ready, y_xfer, r_xfer;
  logic [8:0] in_len, out_len, out_cnt_next;
  logic       out_hit, drain_done, grant_rgb, wd_abort;

  // Source handshakes: only the owner may move data, and only while the CTE is free.
  always_comb begin
    in_len  = owner_q ? RGB_IN_LEN : YUV_IN_LEN;
    out_len = owner_q ? RGB_OUT_LEN : YUV_OUT_LEN;
    y_ready = (state_q == FEED) && !owner_q && !bus.cte_busy && (in_cnt_q < YUV_IN_LEN);
    r_ready = (state_q == FEED) &&  owner_q && !bus.cte_busy && (in_cnt_q < RGB_IN_LEN);
    y_xfer  = y_ready && bus.y_valid;
    r_xfer  = r_ready && bus.r_valid;
    out_hit = bus.cte_out_valid && ((state_q == FEED) || (state_q == DRAIN))
              && (out_cnt_q < out_len);
    out_cnt_next = out_cnt_q + {8'd0, out_hit};
    drain_done   = (state_q == DRAIN) && (out_cnt_next == out_len);
    // On a tie the requester that was not served last wins.
    grant_rgb    = bus.r_req && (!bus.y_req || !last_rgb_q);
  end

  assign bus.y_ready     = y_ready;
  assign bus.r_ready     = r_ready;
  assign bus.cte_in_en   = y_xfer || r_xfer;
  assign bus.cte_yuv_in  = y_xfer ? bus.y_data : 8'd0;
  assign bus.cte_rgb_in  = r_xfer ? bus.r_data : 24'd0;
  assign bus.cte_op_mode = op_mode_q;
  assign bus.owner       = owner_q;
  assign bus.job_done    = drain_done;
  assign bus.job_err     = wd_abort;

`ifdef CTE_SCHED_TIMEOUT_EN
  logic [15:0] idle_cnt_q, idle_cnt_d;

  // Watchdog: count DRAIN cycles since the last CTE output and abort at TIMEOUT.
  always_comb begin
    idle_cnt_d = '0;
    wd_abort   = 1'b0;
    if ((state_q == DRAIN) && !drain_done) begin
      if (bus.cte_out_valid) begin
        idle_cnt_d = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + 16'd1;
        wd_abort   = (idle_cnt_d >= 16'(TIMEOUT));
      end
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  localparam int timeout_unused = TIMEOUT;
  assign wd_abort = 1'b0;
`endif

  // Next-state logic: grant in IDLE, one SETUP cycle, feed inputs, drain outputs.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    op_mode_d  = op_mode_q;
    last_rgb_d = last_rgb_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.y_req || bus.r_req) begin
          state_d    = SETUP;
          owner_d    = grant_rgb;
          op_mode_d  = grant_rgb;
          last_rgb_d = grant_rgb;
          in_cnt_d   = '0;
          out_cnt_d  = '0;
        end
      end
      SETUP: begin
        state_d = FEED;
      end
      FEED: begin
        out_cnt_d = out_cnt_next;
        if (y_xfer || r_xfer) begin
          in_cnt_d = in_cnt_q + 9'd1;
          if ((in_cnt_q + 9'd1) == in_len) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        out_cnt_d = out_cnt_next;
        if (drain_done || wd_abort) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and job bookkeeping registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      op_mode_q  <= 1'b0;
      last_rgb_q <= 1'b1;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      op_mode_q  <= op_mode_d;
      last_rgb_q <= last_rgb_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_cte_scheduler.sv
// tb/tb_cte_scheduler.sv - randomized self-checking bench for cte_scheduler against a job-level model
module tb_cte_scheduler;
  localparam int BL = 4;
  localparam int TO = 10;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   tb_last_rgb = 1'b1;

  always #5 clk = ~clk;

  cte_scheduler_if bus ();

  cte_scheduler #(.BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  function automatic logic [38:0] out_vec();
    return {bus.y_ready, bus.r_ready, bus.cte_op_mode, bus.cte_in_en, bus.cte_yuv_in,
            bus.cte_rgb_in, bus.owner, bus.job_done, bus.job_err};
  endfunction

  task automatic drive_idle();
    bus.y_req = 0; bus.y_valid = 0; bus.y_data = 0;
    bus.r_req = 0; bus.r_valid = 0; bus.r_data = 0;
    bus.cte_busy = 0; bus.cte_out_valid = 0;
  endtask

  // One complete job. The model knows only the rules: grant choice, two cycles to FEED,
  // input/output counts, done = max(cycle after last input, cycle of final output).
  task automatic run_job(input bit yreq, input bit rreq, input bit use_busy,
                         input bit drop_req, input bit withhold);
    bit exp_rgb, finished, busy_now, own_rdy, oth_rdy, exp_rdy, exp_done, exp_err;
    int total_in, exp_out, out_cap, acc, sent, last_in, fin_out, last_out, done_k, err_k, k, busy_s;
    logic [7:0]  yq[$];
    logic [23:0] rq[$];
    logic [7:0]  ey;
    logic [23:0] er;
    exp_rgb     = (yreq && rreq) ? !tb_last_rgb : rreq;
    tb_last_rgb = exp_rgb;
    total_in = exp_rgb ? BL : 2 * BL;
    exp_out  = exp_rgb ? 2 * BL : BL;
    out_cap  = withhold ? exp_out - 1 : exp_out;
    for (int i = 0; i < 2 * BL + 2; i++) begin
      yq.push_back(8'($urandom));
      rq.push_back(24'($urandom));
    end
    acc = 0; sent = 0; last_in = -1; fin_out = -1; last_out = -1; done_k = -1; err_k = -1;
    k = 0; finished = 0;
    busy_s = use_busy ? int'($urandom_range(total_in - 1, 3)) : -100;
    while (!finished && k < 400) begin
      @(posedge clk); #1;
      bus.y_req = yreq; bus.r_req = rreq;
      if (drop_req && acc > 0) begin bus.y_req = 0; bus.r_req = 0; end
      busy_now = (k >= busy_s) && (k < busy_s + 3);
      bus.cte_busy = busy_now;
      bus.y_valid = 1; bus.r_valid = 1;
      bus.y_data = yq[0]; bus.r_data = rq[0];
      bus.cte_out_valid = (acc > 0) && (sent < out_cap) && (!withhold || acc == total_in)
                          && ($urandom_range(1, 0) == 1);
      @(negedge clk);
      own_rdy = exp_rgb ? bus.r_ready : bus.y_ready;
      oth_rdy = exp_rgb ? bus.y_ready : bus.r_ready;
      exp_rdy = (k >= 2) && (acc < total_in) && !busy_now;
      checks++;
      if (own_rdy !== exp_rdy)
        begin errors++; $display("FAIL owner_ready k=%0d: got %b expected %b", k, own_rdy, exp_rdy); end
      checks++;
      if (oth_rdy !== 1'b0)
        begin errors++; $display("FAIL other_ready k=%0d: got %b expected 0", k, oth_rdy); end
      if (own_rdy === 1'b1) begin
        ey = exp_rgb ? 8'd0 : yq[0];
        er = exp_rgb ? rq[0] : 24'd0;
        checks++;
        if ({bus.cte_in_en, bus.cte_yuv_in, bus.cte_rgb_in} !== {1'b1, ey, er}) begin
          errors++;
          $display("FAIL xfer_data k=%0d: got en=%b y=%h r=%h expected en=1 y=%h r=%h",
                   k, bus.cte_in_en, bus.cte_yuv_in, bus.cte_rgb_in, ey, er);
        end
        if (exp_rgb) void'(rq.pop_front()); else void'(yq.pop_front());
        acc++;
        if (acc == total_in) last_in = k;
      end else begin
        checks++;
        if ({bus.cte_in_en, bus.cte_yuv_in, bus.cte_rgb_in} !== 33'd0) begin
          errors++;
          $display("FAIL idle_data k=%0d: got en=%b y=%h r=%h expected all 0",
                   k, bus.cte_in_en, bus.cte_yuv_in, bus.cte_rgb_in);
        end
      end
      if (bus.cte_out_valid) begin
        sent++; last_out = k;
        if (sent == exp_out) fin_out = k;
      end
      if (last_in >= 0 && fin_out >= 0 && done_k < 0)
        done_k = (last_in + 1 > fin_out) ? last_in + 1 : fin_out;
      if (withhold && last_in >= 0 && sent == out_cap && err_k < 0 && last_out >= 0)
        err_k = ((last_out > last_in) ? last_out : last_in) + TO;
      if (k >= 1 && (done_k < 0 || k <= done_k)) begin
        checks++;
        if ({bus.owner, bus.cte_op_mode} !== {exp_rgb, exp_rgb}) begin
          errors++;
          $display("FAIL owner_mode k=%0d: got owner=%b mode=%b expected %b", k, bus.owner,
                   bus.cte_op_mode, exp_rgb);
        end
      end
      exp_done = (k == done_k);
`ifdef CTE_SCHED_TIMEOUT_EN
      exp_err = withhold && (k == err_k);
`else
      exp_err = 1'b0;
`endif
      checks++;
      if (bus.job_done !== exp_done)
        begin errors++; $display("FAIL job_done k=%0d: got %b expected %b", k, bus.job_done, exp_done); end
      checks++;
      if (bus.job_err !== exp_err)
        begin errors++; $display("FAIL job_err k=%0d: got %b expected %b", k, bus.job_err, exp_err); end
      if (!withhold && k == done_k) finished = 1;
`ifdef CTE_SCHED_TIMEOUT_EN
      if (withhold && err_k >= 0 && k == err_k) finished = 1;
`else
      if (withhold && err_k >= 0 && k >= err_k + 5) finished = 1;
`endif
      k++;
    end
    if (!finished) begin
      checks++; errors++;
      $display("FAIL job_budget: got no completion after %0d cycles expected completion", k);
    end
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 0;
    #12;
    checks++;
    if (out_vec() !== 39'd0)
      begin errors++; $display("FAIL reset_outputs: got %h expected 0", out_vec()); end
    @(posedge clk); #1 reset = 1;
    @(negedge clk);
    checks++;
    if (out_vec() !== 39'd0)
      begin errors++; $display("FAIL post_reset_idle: got %h expected 0", out_vec()); end
    tb_last_rgb = 1;
  endtask

  task automatic test_round_robin();
    run_job(1, 1, 0, 0, 0);
    run_job(1, 1, 0, 0, 0);
    run_job(1, 1, 0, 0, 0);
  endtask

  task automatic test_single_sources();
    run_job(1, 0, 0, 0, 0);
    run_job(0, 1, 0, 0, 0);
  endtask

  task automatic test_busy_stall();
    run_job(1, 0, 1, 0, 0);
    run_job(0, 1, 1, 0, 0);
  endtask

  task automatic test_req_drop();
    run_job(1, 1, 0, 1, 0);
    run_job(0, 1, 0, 1, 0);
  endtask

  task automatic test_random_jobs();
    bit yr, rr;
    for (int j = 0; j < 8; j++) begin
      yr = 1'($urandom_range(1, 0));
      rr = 1'($urandom_range(1, 0));
      if (!yr && !rr) yr = 1;
      run_job(yr, rr, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 0);
    end
  endtask

  task automatic test_reset_drain();
    int acc, sent;
    acc = 0; sent = 0;
    for (int k = 0; k < 60 && sent < 2 * BL - 2; k++) begin
      @(posedge clk); #1;
      bus.y_req = 0; bus.r_req = 1; bus.cte_busy = 0;
      bus.r_valid = 1; bus.r_data = 24'h102030 + 24'(acc);
      bus.cte_out_valid = (acc == BL);
      @(negedge clk);
      if (bus.r_ready) acc++;
      if (bus.cte_out_valid) sent++;
    end
    bus.cte_out_valid = 0; bus.r_req = 0;
    checks++;
    if ({bus.owner, bus.cte_op_mode, bus.job_done} !== 3'b110)
      begin errors++; $display("FAIL drain_pending: got %b expected 110", {bus.owner, bus.cte_op_mode, bus.job_done}); end
    #2 reset = 0;
    #1;
    checks++;
    if (out_vec() !== 39'd0)
      begin errors++; $display("FAIL async_reset: got %h expected 0", out_vec()); end
    drive_idle();
    @(posedge clk); #1 reset = 1;
    tb_last_rgb = 1;
    run_job(1, 1, 0, 0, 0);
  endtask

  task automatic test_timeout();
    run_job(0, 1, 0, 0, 1);
`ifdef CTE_SCHED_TIMEOUT_EN
    run_job(1, 0, 0, 0, 0);
`else
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      bus.y_req = 1; bus.r_req = 1; bus.cte_out_valid = 0;
      @(negedge clk);
      checks++;
      if ({bus.y_ready, bus.r_ready, bus.job_done, bus.job_err} !== 4'b0)
        begin errors++; $display("FAIL stuck_drain k=%0d: got %b expected 0000", k,
                                 {bus.y_ready, bus.r_ready, bus.job_done, bus.job_err}); end
    end
    drive_idle();
    reset = 0;
    @(posedge clk); #1 reset = 1;
    tb_last_rgb = 1;
    run_job(1, 1, 0, 0, 0);
`endif
  endtask

  initial begin
    drive_idle();
    reset = 0;
    test_reset();
    test_round_robin();
    test_single_sources();
    test_busy_stall();
    test_req_drop();
    test_random_jobs();
    test_reset_drain();
    test_timeout();
    drive_idle();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
